testbench_ls_pilot_drv: RTL and testbench
=========================================

TESTBENCH_LS_PILOT_DRV -- requirements
Module: testbench_ls_pilot_drv

Interface
REQ-001 SHALL have parameter WIDTH, default 8: number of pilot output bits.
REQ-002 SHALL have parameter CNT_W, default 16: pulse-width counter width.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port address, input, 2 bits: Avalon-MM slave register select.
REQ-006 SHALL have port chipselect, input, 1 bit: slave select.
REQ-007 SHALL have port write_n, input, 1 bit: active-low write strobe.
REQ-008 SHALL have port writedata, input, 32 bits: write data.
REQ-009 SHALL have port readdata, output, 32 bits: registered read data, zero-extended.
REQ-010 SHALL have port out_port, output, WIDTH bits: registered pilot drive lines.

Function
REQ-011 Write strobe SHALL be chipselect && !write_n, sampled at the rising clk edge.
REQ-012 Register map SHALL be: 0 DATA (static level, R/W); 1 PWIDTH (CNT_W bits, R/W); 2 PULSE (write-only mask, reads 0); 3 STATUS (bit0 busy RO, bit1 done W1C, bit2 overrun W1C).
REQ-013 readdata SHALL update every cycle from the address mux, giving 1-cycle read latency regardless of chipselect.
REQ-014 DATA read SHALL return the current out_port value, not data_reg.
REQ-015 FSM SHALL have states IDLE and PULSE.
REQ-016 In IDLE, a PULSE write with a nonzero mask SHALL load mask_reg, load the counter with max(PWIDTH,1), and enter PULSE.
REQ-017 A PULSE write with an all-zero mask SHALL be ignored.
REQ-018 In PULSE, out_port SHALL equal data_reg XOR mask_reg; in IDLE, out_port SHALL equal data_reg.
REQ-019 out_port SHALL change on the first edge after the accepting write edge and remain pulsed for exactly max(PWIDTH,1) cycles.
REQ-020 The counter SHALL decrement each cycle in PULSE; at count 1 the FSM SHALL return to IDLE, clear mask_reg, and set done.
REQ-021 A PULSE write while in PULSE SHALL be ignored and SHALL set overrun; the current pulse continues unchanged.
REQ-022 A DATA write during PULSE SHALL take effect on out_port on the next cycle, still XORed with mask_reg.
REQ-023 A PWIDTH write during PULSE SHALL affect only subsequent pulses.
REQ-024 If a STATUS W1C write and a done-set event occur in the same cycle, the set SHALL win.
REQ-025 busy SHALL equal (state == PULSE).

Reset
REQ-026 On reset_n low, the block SHALL asynchronously set: out_port=0, readdata=0, data_reg=0, PWIDTH=1, mask_reg=0, counter=0, state=IDLE, done=0, overrun=0 (and irq=0 when enabled).
REQ-027 Reset asserted mid-pulse SHALL abort the pulse immediately, with no done set after release.

Configuration
REQ-028 With PILOT_DRV_IRQ_EN defined, the block SHALL add output irq (1 bit), equal to registered (done && irq_en).
REQ-029 With PILOT_DRV_IRQ_EN defined, irq_en SHALL be STATUS bit8 (R/W, reset 0).
REQ-030 Without PILOT_DRV_IRQ_EN, the irq port and bit8 SHALL be absent, and bit8 SHALL read 0.

Structure
REQ-031 Package testbench_ls_pilot_pkg SHALL hold the register address constants, STATUS bit indices, and the state enum type.
REQ-032 Sub-module testbench_ls_pilot_pulse_ctr SHALL contain the FSM and counter (inputs start, len; outputs busy, done_pulse).

Verification
REQ-033 PWIDTH=4, DATA=0x00, PULSE=0x81 -> out_port=0x81 for exactly 4 cycles then 0x00; busy follows; done=1.
REQ-034 DATA=0xFF, PWIDTH=0, PULSE=0x0F -> out_port=0xF0 for exactly 1 cycle, then 0xFF.
REQ-035 PWIDTH=10, PULSE=0x01, second PULSE=0x02 at cycle 3 -> pulse stays 0x01 for 10 cycles; overrun=1; STATUS write 0x4 clears overrun only.
REQ-036 Pulse in progress, reset_n low for 2 cycles -> out_port=0 immediately; after release, STATUS reads 0 and PWIDTH reads 1.
REQ-037 With PILOT_DRV_IRQ_EN defined, irq_en=1, pulse completes -> irq=1; STATUS W1C bit1 -> irq=0 next cycle; W1C coincident with a new done -> done stays 1.

Source files
------------

// File: rtl/testbench_ls_pilot_pkg.sv
// Shared definitions for the pilot-line pulse driver: register map,
// STATUS bit positions and the pulse FSM state type.
package testbench_ls_pilot_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_PWIDTH = 2'd1;
    localparam logic [1:0] ADDR_PULSE  = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_DONE    = 1;
    localparam int STAT_OVERRUN = 2;
    localparam int STAT_IRQ_EN  = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_PULSE = 1'b1
    } pilot_state_e;

endpackage

// File: rtl/testbench_ls_pilot_pulse_ctr.sv
// Pulse FSM with down-counter: a start loads max(len,1) and the block stays
// busy for exactly that many cycles, flagging the final one with done_pulse.
//
// state    | meaning
// ---------+------------------------------------------------------
// ST_IDLE  | no pulse active, start accepted
// ST_PULSE | pulse active, counter holds cycles remaining (>= 1)
module testbench_ls_pilot_pulse_ctr
    import testbench_ls_pilot_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    output logic             busy,
    output logic             done_pulse
);

    localparam logic [CNT_W-1:0] LEN_ONE = CNT_W'(1);

    pilot_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] len_eff;

    assign len_eff = (len == '0) ? LEN_ONE : len;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_PULSE;
                    cnt_d   = len_eff;
                end
            end
            ST_PULSE: begin
                if (cnt_q == LEN_ONE) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - LEN_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        busy       = (state_q == ST_PULSE);
        done_pulse = (state_q == ST_PULSE) && (cnt_q == LEN_ONE);
    end

endmodule

// File: rtl/testbench_ls_pilot_drv.sv
// Avalon-MM pilot-line driver: static DATA level with timed XOR pulses.
// Optional interrupt output enabled by defining PILOT_DRV_IRQ_EN.
module testbench_ls_pilot_drv
    import testbench_ls_pilot_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
`ifdef PILOT_DRV_IRQ_EN
    ,
    output logic             irq
`endif
);

    logic             wr_en;
    logic             wr_data, wr_pwidth, wr_pulse, wr_status;
    logic [WIDTH-1:0] wd_mask;
    logic             pulse_req, start, overrun_set;
    logic             busy, done_pulse;
    logic             unused_wd;

    logic [WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0] pwidth_q, pwidth_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic             done_q, done_d;
    logic             overrun_q, overrun_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [31:0]      rd_q, rd_d;
`ifdef PILOT_DRV_IRQ_EN
    logic             irq_en_q, irq_en_d;
    logic             irq_q, irq_d;
`endif

    assign wr_en     = chipselect && !write_n;
    assign wr_data   = wr_en && (address == ADDR_DATA);
    assign wr_pwidth = wr_en && (address == ADDR_PWIDTH);
    assign wr_pulse  = wr_en && (address == ADDR_PULSE);
    assign wr_status = wr_en && (address == ADDR_STATUS);
    assign wd_mask   = writedata[WIDTH-1:0];
    assign unused_wd = ^writedata;

    // Zero masks never start a pulse nor count as an overrun.
    assign pulse_req   = wr_pulse && (wd_mask != '0);
    assign start       = pulse_req && !busy;
    assign overrun_set = pulse_req && busy;

    testbench_ls_pilot_pulse_ctr #(
        .CNT_W (CNT_W)
    ) u_pulse_ctr (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .len        (pwidth_q),
        .busy       (busy),
        .done_pulse (done_pulse)
    );

    always_comb begin
        data_d    = wr_data   ? wd_mask                   : data_q;
        pwidth_d  = wr_pwidth ? writedata[CNT_W-1:0]      : pwidth_q;

        mask_d = mask_q;
        if (start) begin
            mask_d = wd_mask;
        end else if (done_pulse) begin
            mask_d = '0;
        end

        // Set events take priority over a coincident write-1-to-clear.
        done_d = done_q;
        if (wr_status && writedata[STAT_DONE]) begin
            done_d = 1'b0;
        end
        if (done_pulse) begin
            done_d = 1'b1;
        end

        overrun_d = overrun_q;
        if (wr_status && writedata[STAT_OVERRUN]) begin
            overrun_d = 1'b0;
        end
        if (overrun_set) begin
            overrun_d = 1'b1;
        end

        out_d = busy ? (data_q ^ mask_q) : data_q;
    end

`ifdef PILOT_DRV_IRQ_EN
    always_comb begin
        irq_en_d = wr_status ? writedata[STAT_IRQ_EN] : irq_en_q;
        irq_d    = done_q && irq_en_q;
    end
`endif

    // DATA reads back the driven lines, so a pulse is visible to software.
    always_comb begin
        rd_d = '0;
        case (address)
            ADDR_DATA:   rd_d[WIDTH-1:0] = out_q;
            ADDR_PWIDTH: rd_d[CNT_W-1:0] = pwidth_q;
            ADDR_PULSE:  rd_d            = '0;
            default: begin
                rd_d[STAT_BUSY]    = busy;
                rd_d[STAT_DONE]    = done_q;
                rd_d[STAT_OVERRUN] = overrun_q;
`ifdef PILOT_DRV_IRQ_EN
                rd_d[STAT_IRQ_EN]  = irq_en_q;
`endif
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q    <= '0;
            pwidth_q  <= CNT_W'(1);
            mask_q    <= '0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            out_q     <= '0;
            rd_q      <= '0;
        end else begin
            data_q    <= data_d;
            pwidth_q  <= pwidth_d;
            mask_q    <= mask_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
            out_q     <= out_d;
            rd_q      <= rd_d;
        end
    end

`ifdef PILOT_DRV_IRQ_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            irq_q    <= irq_d;
        end
    end

    assign irq = irq_q;
`endif

    assign readdata = rd_q;
    assign out_port = out_q;

endmodule

// File: tb/tb_testbench_ls_pilot_drv.sv
// Self-checking bench for testbench_ls_pilot_drv: vector table, directed
// corner sequences and a randomized run against a cycle-level model.
module tb_testbench_ls_pilot_drv;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  out_port;
`ifdef PILOT_DRV_IRQ_EN
    logic        irq;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    testbench_ls_pilot_drv #(
        .WIDTH (8),
        .CNT_W (16)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
`ifdef PILOT_DRV_IRQ_EN
        ,
        .irq        (irq)
`endif
    );

    typedef struct {
        logic [1:0]  a;
        logic        cs;
        logic        wn;
        logic [31:0] wd;
        logic [7:0]  eo;
        logic [31:0] er;
    } vec_t;

    vec_t tbl[19];

    // Reference model: pulse tracked as an absolute edge window (start, end].
    int          n;
    int          m_start, m_end;
    logic [7:0]  m_data, m_mask, m_out;
    logic [15:0] m_pw;
    bit          m_done, m_ovr, m_irqen, m_irq;
    logic [31:0] m_rd;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] a, input logic cs, input logic wn, input logic [31:0] wd);
        @(negedge clk);
        address    = a;
        chipselect = cs;
        write_n    = wn;
        writedata  = wd;
        @(posedge clk);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] wd);
        drive(a, 1'b1, 1'b0, wd);
        #1;
    endtask

    task automatic rd(input logic [1:0] a);
        drive(a, 1'b1, 1'b1, 32'h0);
        #1;
    endtask

    task automatic idle();
        drive(2'd0, 1'b0, 1'b1, 32'h0);
        #1;
    endtask

    task automatic model_reset();
        n = 0; m_start = 0; m_end = 0;
        m_data = 8'h00; m_mask = 8'h00; m_out = 8'h00; m_pw = 16'd1;
        m_done = 0; m_ovr = 0; m_irqen = 0; m_irq = 0; m_rd = 32'h0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n    = 1'b0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic model_step(input logic [1:0] a, input logic cs, input logic wn, input logic [31:0] wd);
        bit busy_pre, fin;
        int len;
        n++;
        busy_pre = (n > m_start) && (n <= m_end);
        fin      = busy_pre && (n == m_end);
        case (a)
            2'd0:    m_rd = {24'h0, m_out};
            2'd1:    m_rd = {16'h0, m_pw};
            2'd2:    m_rd = 32'h0;
            default: m_rd = (32'(m_irqen) << 8) | (32'(m_ovr) << 2) | (32'(m_done) << 1) | 32'(busy_pre);
        endcase
        m_irq = m_done && m_irqen;
        m_out = busy_pre ? (m_data ^ m_mask) : m_data;
        if (cs && !wn) begin
            case (a)
                2'd0: m_data = wd[7:0];
                2'd1: m_pw   = wd[15:0];
                2'd2: begin
                    if (wd[7:0] != 8'h00) begin
                        if (busy_pre) begin
                            m_ovr = 1;
                        end else begin
                            len     = (m_pw == 16'd0) ? 1 : int'(m_pw);
                            m_start = n;
                            m_end   = n + len;
                            m_mask  = wd[7:0];
                        end
                    end
                end
                default: begin
                    if (wd[1]) m_done = 0;
                    if (wd[2]) m_ovr = 0;
`ifdef PILOT_DRV_IRQ_EN
                    m_irqen = wd[8];
`endif
                end
            endcase
        end
        if (fin) m_done = 1;
    endtask

    task automatic rand_step();
        logic [1:0]  a;
        logic        cs, wn;
        logic [31:0] wd;
        int          r;
        r  = $urandom_range(0, 11);
        wd = $urandom();
        cs = 1'b1;
        wn = 1'b0;
        case (r)
            0, 1: a = 2'd0;
            2:    begin a = 2'd1; wd[15:0] = 16'($urandom_range(0, 6)); end
            3, 4: begin a = 2'd2; if ($urandom_range(0, 3) == 0) wd[7:0] = 8'h00; end
            5:    a = 2'd3;
            6:    begin a = 2'($urandom_range(0, 3)); cs = 1'b0; end
            default: begin a = 2'($urandom_range(0, 3)); wn = 1'b1; end
        endcase
        drive(a, cs, wn, wd);
        model_step(a, cs, wn, wd);
        #1;
        chk("rand_out", {24'h0, out_port}, {24'h0, m_out});
        chk("rand_rd", readdata, m_rd);
`ifdef PILOT_DRV_IRQ_EN
        chk("rand_irq", {31'h0, irq}, {31'h0, m_irq});
`endif
    endtask

    initial begin
        // Single pulse of width 4, then zero width clamped to 1 and a zero mask.
        tbl[0]  = '{2'd1, 1'b1, 1'b0, 32'd4,    8'h00, 32'd1};
        tbl[1]  = '{2'd0, 1'b1, 1'b0, 32'h00,   8'h00, 32'h0};
        tbl[2]  = '{2'd2, 1'b1, 1'b0, 32'h81,   8'h00, 32'h0};
        tbl[3]  = '{2'd3, 1'b1, 1'b1, 32'h0,    8'h81, 32'h1};
        tbl[4]  = '{2'd3, 1'b1, 1'b1, 32'h0,    8'h81, 32'h1};
        tbl[5]  = '{2'd0, 1'b1, 1'b1, 32'h0,    8'h81, 32'h81};
        tbl[6]  = '{2'd3, 1'b1, 1'b1, 32'h0,    8'h81, 32'h1};
        tbl[7]  = '{2'd3, 1'b1, 1'b1, 32'h0,    8'h00, 32'h2};
        tbl[8]  = '{2'd0, 1'b1, 1'b1, 32'h0,    8'h00, 32'h0};
        tbl[9]  = '{2'd3, 1'b1, 1'b0, 32'h2,    8'h00, 32'h2};
        tbl[10] = '{2'd3, 1'b1, 1'b1, 32'h0,    8'h00, 32'h0};
        tbl[11] = '{2'd0, 1'b1, 1'b0, 32'hFF,   8'h00, 32'h0};
        tbl[12] = '{2'd1, 1'b1, 1'b0, 32'h0,    8'hFF, 32'd4};
        tbl[13] = '{2'd2, 1'b1, 1'b0, 32'h0F,   8'hFF, 32'h0};
        tbl[14] = '{2'd3, 1'b1, 1'b1, 32'h0,    8'hF0, 32'h1};
        tbl[15] = '{2'd3, 1'b1, 1'b1, 32'h0,    8'hFF, 32'h2};
        tbl[16] = '{2'd1, 1'b1, 1'b1, 32'h0,    8'hFF, 32'h0};
        tbl[17] = '{2'd2, 1'b1, 1'b0, 32'h00,   8'hFF, 32'h0};
        tbl[18] = '{2'd3, 1'b1, 1'b1, 32'h0,    8'hFF, 32'h2};

        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
        #2;
        chk("reset_out", {24'h0, out_port}, 32'h0);
        chk("reset_rd", readdata, 32'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 19; i++) begin
            drive(tbl[i].a, tbl[i].cs, tbl[i].wn, tbl[i].wd);
            #1;
            chk($sformatf("tbl%0d_out", i), {24'h0, out_port}, {24'h0, tbl[i].eo});
            chk($sformatf("tbl%0d_rd", i), readdata, tbl[i].er);
        end

        // Overrun: second pulse request mid-pulse is dropped.
        wr(2'd0, 32'h00);
        wr(2'd1, 32'd10);
        wr(2'd3, 32'h6);
        idle();
        wr(2'd2, 32'h01);
        for (int k = 1; k <= 12; k++) begin
            if (k == 3) wr(2'd2, 32'h02);
            else idle();
            chk($sformatf("ovr_out_c%0d", k), {24'h0, out_port}, (k <= 10) ? 32'h01 : 32'h00);
        end
        rd(2'd3);
        chk("ovr_status", readdata, 32'h6);
        wr(2'd3, 32'h4);
        rd(2'd3);
        chk("ovr_w1c", readdata, 32'h2);

        // DATA and PWIDTH writes during a pulse.
        wr(2'd3, 32'h6);
        wr(2'd2, 32'h0F);
        idle();
        chk("mid_e1", {24'h0, out_port}, 32'h0F);
        wr(2'd0, 32'hA0);
        chk("mid_e2", {24'h0, out_port}, 32'h0F);
        wr(2'd1, 32'd2);
        chk("mid_e3", {24'h0, out_port}, 32'hAF);
        for (int k = 4; k <= 11; k++) begin
            idle();
            chk($sformatf("mid_e%0d", k), {24'h0, out_port}, (k <= 10) ? 32'hAF : 32'hA0);
        end
        wr(2'd2, 32'h01);
        idle();
        chk("pw2_e1", {24'h0, out_port}, 32'hA1);
        idle();
        chk("pw2_e2", {24'h0, out_port}, 32'hA1);
        idle();
        chk("pw2_e3", {24'h0, out_port}, 32'hA0);

        // Reset in the middle of a pulse.
        wr(2'd1, 32'd5);
        wr(2'd2, 32'h3C);
        idle();
        idle();
        chk("prerst_out", {24'h0, out_port}, 32'h9C);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_out", {24'h0, out_port}, 32'h0);
        chk("rst_rd", readdata, 32'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        rd(2'd3);
        chk("rst_status", readdata, 32'h0);
        rd(2'd1);
        chk("rst_pwidth", readdata, 32'h1);
        repeat (6) idle();
        rd(2'd3);
        chk("rst_nodone", readdata, 32'h0);
        chk("rst_out_after", {24'h0, out_port}, 32'h0);

`ifdef PILOT_DRV_IRQ_EN
        wr(2'd3, 32'h100);
        wr(2'd1, 32'd2);
        wr(2'd2, 32'h01);
        idle();
        idle();
        chk("irq_low", {31'h0, irq}, 32'h0);
        idle();
        chk("irq_high", {31'h0, irq}, 32'h1);
        wr(2'd3, 32'h102);
        idle();
        chk("irq_cleared", {31'h0, irq}, 32'h0);
        wr(2'd2, 32'h01);
        idle();
        wr(2'd3, 32'h102);
        rd(2'd3);
        chk("irq_set_wins", readdata, 32'h102);
`endif

        do_reset();
        for (int i = 0; i < 400; i++) rand_step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
